dot_product_sequencer: RTL and testbench

Controller that sequences the shared MAC datapath through one complete N-element dot product per request. On start it latches the packed operand vectors, clears the MAC accumulator, and issues one element pair per cycle with mac_enable. It then captures the accumulator and overflow flag into a held result register and pulses done. It sits between the switch/input logic (the vector source) and the MAC, and the display reads its result outputs.

---
 rtl/dot_product_sequencer.sv | 127 ++++++++++++
 tb/tb_dot_product_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Sequences a shared MAC through one N_ELEM-element dot product per request.
// It latches the operands, clears the MAC, feeds one pair per cycle, then captures and holds the result.
module dot_product_sequencer #(
    parameter int N_ELEM = 4,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_ELEM*ELEM_W-1:0] a_vec,
    input  logic [N_ELEM*ELEM_W-1:0] b_vec,
    input  logic [ACC_W-1:0]         acc_in,
    input  logic                     oflow_in,
    output logic [ELEM_W-1:0]        mac_a,
    output logic [ELEM_W-1:0]        mac_b,
    output logic                     mac_enable,
    output logic                     mac_clear,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W-1:0]         result,
    output logic                     result_oflow
);

    localparam int IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_ELEM*ELEM_W-1:0] a_lat_q, a_lat_d;
    logic [N_ELEM*ELEM_W-1:0] b_lat_q, b_lat_d;
    logic [ACC_W-1:0]         result_q, result_d;
    logic                     result_oflow_q, result_oflow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            a_lat_q        <= '0;
            b_lat_q        <= '0;
            result_q       <= '0;
            result_oflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            a_lat_q        <= a_lat_d;
            b_lat_q        <= b_lat_d;
            result_q       <= result_d;
            result_oflow_q <= result_oflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        a_lat_d        = a_lat_q;
        b_lat_d        = b_lat_q;
        result_d       = result_q;
        result_oflow_d = result_oflow_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // start is honoured in IDLE and DONE alike, which gives back-to-back operation
                if (start) begin
                    a_lat_d = a_vec;
                    b_lat_d = b_vec;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    result_d       = acc_in;
                    result_oflow_d = oflow_in;
                    state_d        = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state_q == S_FEED) begin
            mac_a = a_lat_q[idx_q*ELEM_W +: ELEM_W];
            mac_b = b_lat_q[idx_q*ELEM_W +: ELEM_W];
        end
    end

    assign mac_enable   = (state_q == S_FEED);
    assign mac_clear    = (state_q == S_CLEAR);
    assign busy         = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign result       = result_q;
    assign result_oflow = result_oflow_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer driving a behavioural 16-bit MAC with sticky carry-out overflow.
module tb_dot_product_sequencer;

    localparam int N_ELEM = 4;
    localparam int ELEM_W = 8;
    localparam int ACC_W  = 16;

    logic                     clk = 1'b0;
    logic                     rst, start, abort;
    logic [N_ELEM*ELEM_W-1:0] a_vec, b_vec;
    logic [ACC_W-1:0]         acc_in;
    logic                     oflow_in;
    logic [ELEM_W-1:0]        mac_a, mac_b;
    logic                     mac_enable, mac_clear, busy, done;
    logic [ACC_W-1:0]         result;
    logic                     result_oflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dot_product_sequencer #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_vec(a_vec), .b_vec(b_vec), .acc_in(acc_in), .oflow_in(oflow_in),
        .mac_a(mac_a), .mac_b(mac_b), .mac_enable(mac_enable), .mac_clear(mac_clear),
        .busy(busy), .done(done), .result(result), .result_oflow(result_oflow)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: not reset, so a reset mid-operation leaves it uncleared
    logic [2*ELEM_W-1:0] mac_prod;
    logic [ACC_W:0]      mac_sum;
    initial begin
        acc_in   = '0;
        oflow_in = 1'b0;
    end
    always_comb begin
        mac_prod = mac_a * mac_b;
        mac_sum  = {1'b0, acc_in} + {1'b0, mac_prod};
    end
    always @(posedge clk) begin
        if (mac_clear) begin
            acc_in   <= '0;
            oflow_in <= 1'b0;
        end else if (mac_enable) begin
            acc_in   <= mac_sum[ACC_W-1:0];
            oflow_in <= oflow_in | mac_sum[ACC_W];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {mac_clear, mac_enable, mac_a, mac_b, busy, done} for cycle c of a normal run
    function automatic logic [19:0] exp_ctl(input int c, input logic [31:0] av, input logic [31:0] bv);
        logic en;
        logic [7:0] ea, eb;
        en = (c >= 2) && (c <= 5);
        ea = en ? av[(c-2)*8 +: 8] : 8'h00;
        eb = en ? bv[(c-2)*8 +: 8] : 8'h00;
        return {(c == 1), en, ea, eb, (c >= 1) && (c <= 6), (c == 7)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; a_vec = '0; b_vec = '0;
        tick(); tick();
        total_cnt++;
        if ({mac_a, mac_b, mac_enable, mac_clear, busy, done, result, result_oflow} !== '0)
            $display("FAIL reset_outputs: got a=%h b=%h en=%b clr=%b busy=%b done=%b res=%h of=%b, want all 0",
                     mac_a, mac_b, mac_enable, mac_clear, busy, done, result, result_oflow);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    // Launches one op with start (and optional abort) high for edge 0, then checks cycles 1..7
    task automatic run_normal(input string name, input logic [31:0] av, input logic [31:0] bv,
                              input logic with_abort, input logic [15:0] exp_res, input logic exp_of);
        a_vec = av; b_vec = bv; start = 1'b1; abort = with_abort;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0; abort = 1'b0;
            total_cnt++;
            if ({mac_clear, mac_enable, mac_a, mac_b, busy, done} !== exp_ctl(c, av, bv))
                $display("FAIL %s_ctl_cycle%0d: got %h, want %h", name, c,
                         {mac_clear, mac_enable, mac_a, mac_b, busy, done}, exp_ctl(c, av, bv));
            else pass_cnt++;
        end
        total_cnt++;
        if ({result, result_oflow} !== {exp_res, exp_of})
            $display("FAIL %s_result: got %h of=%b, want %h of=%b", name, result, result_oflow, exp_res, exp_of);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL %s_idle_after: got busy=%b done=%b, want 0 0", name, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_normal("basic", 32'h04030201, 32'h08070605, 1'b0, 16'h0046, 1'b0);
    endtask

    task automatic test_abort();
        a_vec = 32'h0A0A0A0A; b_vec = 32'h01010101; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
        end
        total_cnt++;
        if (mac_a !== 8'h0A || mac_enable !== 1'b1)
            $display("FAIL abort_pre: got mac_a=%h en=%b, want 0a 1", mac_a, mac_enable);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if ({busy, mac_enable, mac_a, done} !== '0)
            $display("FAIL abort_idle: got busy=%b en=%b a=%h done=%b, want all 0", busy, mac_enable, mac_a, done);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            tick();
            total_cnt++;
            if ({done, busy, result, result_oflow} !== {2'b00, 16'h0046, 1'b0})
                $display("FAIL abort_hold%0d: got done=%b busy=%b res=%h of=%b, want 0 0 0046 0",
                         c, done, busy, result, result_oflow);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        run_normal("oflow", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'hF804, 1'b1);
    endtask

    task automatic test_back_to_back();
        a_vec = 32'h04030201; b_vec = 32'h08070605; start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 3) a_vec = 32'h10101010;
            if (c == 13) start = 1'b0;
            total_cnt++;
            if ({mac_clear, done} !== {(c == 1) || (c == 8), (c == 7) || (c == 14)})
                $display("FAIL b2b_cycle%0d: got clr=%b done=%b, want %b %b", c, mac_clear, done,
                         (c == 1) || (c == 8), (c == 7) || (c == 14));
            else pass_cnt++;
            if (c == 7) begin
                total_cnt++;
                if (result !== 16'h0046)
                    $display("FAIL b2b_first_result: got %h, want 0046", result);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (result !== 16'h01A0)
            $display("FAIL b2b_second_result: got %h, want 01a0", result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({busy, done, mac_clear} !== 3'b000)
            $display("FAIL b2b_end: got busy=%b done=%b clr=%b, want 0 0 0", busy, done, mac_clear);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        a_vec = 32'h04030201; b_vec = 32'h08070605; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({mac_a, mac_b, mac_enable, mac_clear, busy, done, result, result_oflow} !== '0)
            $display("FAIL reset_mid_outputs: got a=%h b=%h en=%b clr=%b busy=%b done=%b res=%h of=%b, want all 0",
                     mac_a, mac_b, mac_enable, mac_clear, busy, done, result, result_oflow);
        else pass_cnt++;
        tick();
        run_normal("after_reset", 32'h04030201, 32'h08070605, 1'b0, 16'h0046, 1'b0);
    endtask

    task automatic test_abort_start_idle();
        run_normal("abort_idle_start", 32'h04030201, 32'h08070605, 1'b1, 16'h0046, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_abort_start_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
